sargantana_icache_ifill_responder: RTL and testbench

- Memory-side end of the instruction-cache IFILL protocol.
- Accepts one line-fill request from the icache controller, issues one burst read on a simple memory read channel, and assembles the returned beats into a full cache line.
- Delivers the line to the icache in a single-cycle response.
- Holds the "request sent" acknowledge high for the whole time a fill is outstanding. The controller uses this to know when a killed miss has drained.

---
 rtl/sargantana_icache_ifill_responder_pkg.sv | 13 +
 rtl/sargantana_icache_ifill_responder_if.sv | 39 +++
 rtl/sargantana_icache_ifill_responder.sv | 83 ++++++++
 tb/tb_sargantana_icache_ifill_responder.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/sargantana_icache_ifill_responder_pkg.sv
// sargantana_icache_ifill_responder_pkg: FSM state type, default geometry and line-offset helper for the IFILL responder.
package sargantana_icache_ifill_responder_pkg;
   typedef enum logic [2:0] {IDLE, REQ, RESP, DRAIN, DELIVER} ifill_rsp_state_t;
   localparam int IFILL_PADDR_W = 40;
   localparam int IFILL_LINE_W = 512;
   localparam int IFILL_MEM_W = 128;
   localparam int IFILL_TIMEOUT = 1024;
   localparam int IFILL_BEATS = IFILL_LINE_W / IFILL_MEM_W;
   localparam int IFILL_OFF_W = $clog2(IFILL_LINE_W / 8);
   function automatic int line_off_w(input int line_w);
      return $clog2(line_w / 8);
   endfunction
endpackage

// File: rtl/sargantana_icache_ifill_responder_if.sv
// sargantana_icache_ifill_responder_if: IFILL request/response and memory read channel bundle.
//   ifill_req_*  : line-fill request from the icache controller
//   ifill_*_o    : sent-ack level plus single-cycle line response
//   mem_req_*    : burst read request with ready handshake
//   mem_rsp_*    : returned beats, no backpressure
//   slave modport is the responder, master modport is the controller/memory side.
interface sargantana_icache_ifill_responder_if #(
   parameter int PADDR_W = 40,
   parameter int LINE_W = 512,
   parameter int MEM_W = 128
);
   logic ifill_req_valid_i;
   logic [PADDR_W-1:0] ifill_req_paddr_i;
   logic ifill_sent_ack_o;
   logic ifill_resp_valid_o;
   logic ifill_resp_done_o;
   logic ifill_resp_err_o;
   logic [LINE_W-1:0] ifill_resp_data_o;
   logic mem_req_valid_o;
   logic mem_req_ready_i;
   logic [PADDR_W-1:0] mem_req_addr_o;
   logic [7:0] mem_req_len_o;
   logic mem_rsp_valid_i;
   logic [MEM_W-1:0] mem_rsp_data_i;
   logic mem_rsp_last_i;
   logic mem_rsp_err_i;
   modport slave (
      input ifill_req_valid_i, ifill_req_paddr_i, mem_req_ready_i,
            mem_rsp_valid_i, mem_rsp_data_i, mem_rsp_last_i, mem_rsp_err_i,
      output ifill_sent_ack_o, ifill_resp_valid_o, ifill_resp_done_o, ifill_resp_err_o,
             ifill_resp_data_o, mem_req_valid_o, mem_req_addr_o, mem_req_len_o
   );
   modport master (
      output ifill_req_valid_i, ifill_req_paddr_i, mem_req_ready_i,
             mem_rsp_valid_i, mem_rsp_data_i, mem_rsp_last_i, mem_rsp_err_i,
      input ifill_sent_ack_o, ifill_resp_valid_o, ifill_resp_done_o, ifill_resp_err_o,
            ifill_resp_data_o, mem_req_valid_o, mem_req_addr_o, mem_req_len_o
   );
endinterface

// File: rtl/sargantana_icache_ifill_responder.sv
// sargantana_icache_ifill_responder: accepts one icache line fill, issues one burst read and returns the assembled line.
//   clk_i, rst_i : clock and synchronous active-high reset
//   bus (slave)  : IFILL request/response and memory read channel
module sargantana_icache_ifill_responder
   import sargantana_icache_ifill_responder_pkg::*;
#(
   parameter int PADDR_W = IFILL_PADDR_W,
   parameter int LINE_W = IFILL_LINE_W,
   parameter int MEM_W = IFILL_MEM_W,
   parameter int TIMEOUT = IFILL_TIMEOUT
) (
   input logic clk_i,
   input logic rst_i,
   sargantana_icache_ifill_responder_if.slave bus
);
   localparam int BEATS = LINE_W / MEM_W;
   localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int OFF_W = line_off_w(LINE_W);
   localparam logic [PADDR_W-1:0] LINE_MASK = {{(PADDR_W - OFF_W){1'b1}}, {OFF_W{1'b0}}};
   ifill_rsp_state_t state_q, state_d;
   logic [PADDR_W-1:0] addr_q;
   logic [LINE_W-1:0] line_q;
   logic [CW-1:0] cnt_q;
   logic [TW-1:0] tcnt_q;
   logic err_q;
   logic beat, cnt_end, tmo;
   assign beat = bus.mem_rsp_valid_i;
   assign cnt_end = cnt_q == CW'(BEATS - 1);
   assign tmo = tcnt_q == TW'(TIMEOUT - 1);
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else state_q <= state_d;
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: state_d = bus.ifill_req_valid_i ? REQ : IDLE;
         REQ: state_d = bus.mem_req_ready_i ? RESP : REQ;
         RESP: state_d = beat ? ((bus.mem_rsp_last_i || cnt_end) ? DELIVER : RESP) : (tmo ? DRAIN : RESP);
         DRAIN: state_d = (beat && bus.mem_rsp_last_i) ? DELIVER : DRAIN;
         DELIVER: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // A last flag that disagrees with the beat count marks the line bad but still ends the burst.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr_q <= '0;
         line_q <= '0;
         cnt_q <= '0;
         tcnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (state_q == IDLE && bus.ifill_req_valid_i) addr_q <= bus.ifill_req_paddr_i;
         if (state_q == RESP && beat) begin
            line_q[int'(cnt_q)*MEM_W +: MEM_W] <= bus.mem_rsp_data_i;
            cnt_q <= cnt_q + 1'b1;
            tcnt_q <= '0;
            err_q <= err_q | bus.mem_rsp_err_i | (bus.mem_rsp_last_i != cnt_end);
         end
         if (state_q == RESP && !beat) begin
            tcnt_q <= tcnt_q + 1'b1;
            if (tmo) err_q <= 1'b1;
         end
         if (state_q == DELIVER) begin
            cnt_q <= '0;
            tcnt_q <= '0;
            err_q <= 1'b0;
         end
      end
   end
   always_comb begin
      bus.ifill_sent_ack_o = state_q != IDLE;
      bus.ifill_resp_valid_o = state_q == DELIVER;
      bus.ifill_resp_err_o = state_q == DELIVER && err_q;
      bus.ifill_resp_done_o = state_q == DELIVER && !err_q;
      bus.ifill_resp_data_o = line_q;
      bus.mem_req_valid_o = state_q == REQ;
      bus.mem_req_addr_o = addr_q & LINE_MASK;
      bus.mem_req_len_o = 8'(BEATS - 1);
   end
endmodule

// File: tb/tb_sargantana_icache_ifill_responder.sv
// tb_sargantana_icache_ifill_responder: directed and randomized fills checked against a line-level reference model.
module tb_sargantana_icache_ifill_responder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int total = 0;
   int passes = 0;
   int fails = 0;
   int reqs = 0;
   int pulses = 0;
   logic prev_req = 1'b0;
   logic [511:0] line_m = '0;
   sargantana_icache_ifill_responder_if #(.PADDR_W(40), .LINE_W(512), .MEM_W(128)) bus ();
   sargantana_icache_ifill_responder #(.PADDR_W(40), .LINE_W(512), .MEM_W(128), .TIMEOUT(16)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (bus.mem_req_valid_o === 1'b1 && prev_req !== 1'b1) reqs++;
      prev_req = bus.mem_req_valid_o;
      if (bus.ifill_resp_valid_o === 1'b1) pulses++;
   end
   task automatic cyc();
      @(negedge clk);
   endtask
   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic logic [127:0] rnd();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction
   task automatic start(input logic [39:0] pa, input int rdelay);
      logic [39:0] la;
      la = {pa[39:6], 6'b0};
      bus.ifill_req_valid_i = 1'b1;
      bus.ifill_req_paddr_i = pa;
      cyc();
      bus.ifill_req_valid_i = 1'b0;
      bus.ifill_req_paddr_i = ~pa;
      chk("req_issue", {bus.ifill_sent_ack_o, bus.mem_req_valid_o, bus.mem_req_len_o, bus.mem_req_addr_o}, {2'b11, 8'd3, la});
      for (int i = 0; i < rdelay; i++) begin
         cyc();
         chk("req_hold", {bus.mem_req_valid_o, bus.mem_req_addr_o}, {1'b1, la});
      end
      bus.mem_req_ready_i = 1'b1;
      cyc();
      bus.mem_req_ready_i = 1'b0;
   endtask
   task automatic send(input logic [127:0] d, input bit last, input bit err, input int gap, input bit poke);
      for (int i = 0; i < gap; i++) begin
         bus.ifill_req_valid_i = poke && i == 0;
         cyc();
         bus.ifill_req_valid_i = 1'b0;
         chk("busy", {bus.ifill_resp_valid_o, bus.ifill_sent_ack_o, bus.mem_req_valid_o}, 3'b010);
      end
      bus.mem_rsp_valid_i = 1'b1;
      bus.mem_rsp_data_i = d;
      bus.mem_rsp_last_i = last;
      bus.mem_rsp_err_i = err;
      cyc();
      bus.mem_rsp_valid_i = 1'b0;
      bus.mem_rsp_last_i = 1'b0;
      bus.mem_rsp_err_i = 1'b0;
      bus.mem_rsp_data_i = rnd();
   endtask
   task automatic finish(input bit exp_err, input bit poke);
      chk("resp", {bus.ifill_resp_valid_o, bus.ifill_resp_err_o, bus.ifill_resp_done_o, bus.ifill_sent_ack_o}, {1'b1, exp_err, !exp_err, 1'b1});
      chk("data", bus.ifill_resp_data_o, line_m);
      bus.ifill_req_valid_i = poke;
      cyc();
      bus.ifill_req_valid_i = 1'b0;
      chk("after", {bus.ifill_resp_valid_o, bus.ifill_sent_ack_o, bus.mem_req_valid_o}, 3'b000);
   endtask
   // The model fills consumed beats into the retained line; a burst is clean only if it
   // delivers exactly four beats, marks last on the fourth, and no beat reports an error.
   task automatic fill(input logic [39:0] pa, input int rdelay, input int gap, input int nsend,
                       input bit last_final, input logic [3:0] errm, input bit poke_resp, input bit poke_del);
      int r0, p0;
      bit e;
      logic [127:0] d;
      r0 = reqs;
      p0 = pulses;
      e = 1'b0;
      start(pa, rdelay);
      for (int b = 0; b < nsend; b++) begin
         d = rnd();
         send(d, last_final && b == nsend - 1, errm[b], gap, poke_resp && b == 1);
         line_m[b*128 +: 128] = d;
         e |= errm[b];
      end
      e |= !(nsend == 4 && last_final);
      finish(e, poke_del);
      cyc();
      chk("one_req", 32'(reqs - r0), 32'd1);
      chk("one_resp", 32'(pulses - p0), 32'd1);
   endtask
   initial begin
      int r0, p0, mode, ns;
      logic [127:0] d;
      bus.ifill_req_valid_i = 1'b0;
      bus.ifill_req_paddr_i = '0;
      bus.mem_req_ready_i = 1'b0;
      bus.mem_rsp_valid_i = 1'b0;
      bus.mem_rsp_data_i = '0;
      bus.mem_rsp_last_i = 1'b0;
      bus.mem_rsp_err_i = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
      chk("rst_ctl", {bus.ifill_sent_ack_o, bus.ifill_resp_valid_o, bus.ifill_resp_done_o, bus.ifill_resp_err_o, bus.mem_req_valid_o}, 5'b0);
      chk("rst_data", bus.ifill_resp_data_o, 512'b0);
      chk("rst_addr", bus.mem_req_addr_o, 40'b0);
      cyc();
      fill(40'h80001234, 0, 0, 4, 1'b1, 4'b0000, 1'b0, 1'b0);
      fill(40'h00abcdef7f, 5, 3, 4, 1'b1, 4'b0000, 1'b1, 1'b1);
      fill(40'h1200000040, 1, 1, 4, 1'b1, 4'b0100, 1'b0, 1'b0);
      fill(40'h3300000080, 0, 2, 2, 1'b1, 4'b0000, 1'b0, 1'b0);
      fill(40'h44000000c0, 2, 0, 4, 1'b0, 4'b0000, 1'b0, 1'b0);
      fill(40'h5500000100, 0, 15, 4, 1'b1, 4'b0000, 1'b0, 1'b0);
      r0 = reqs;
      p0 = pulses;
      start(40'h6600000140, 0);
      d = rnd();
      send(d, 1'b0, 1'b0, 0, 1'b0);
      line_m[127:0] = d;
      for (int i = 0; i < 16; i++) begin
         cyc();
         chk("tmo_wait", {bus.ifill_resp_valid_o, bus.ifill_sent_ack_o}, 2'b01);
      end
      send(rnd(), 1'b0, 1'b0, 0, 1'b0);
      send(rnd(), 1'b0, 1'b0, 1, 1'b0);
      send(rnd(), 1'b1, 1'b0, 0, 1'b0);
      finish(1'b1, 1'b0);
      cyc();
      chk("tmo_req", 32'(reqs - r0), 32'd1);
      chk("tmo_resp", 32'(pulses - p0), 32'd1);
      r0 = reqs;
      p0 = pulses;
      start(40'h7700000180, 1);
      send(rnd(), 1'b0, 1'b0, 0, 1'b0);
      send(rnd(), 1'b0, 1'b0, 2, 1'b1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      line_m = '0;
      chk("midrst_ctl", {bus.ifill_sent_ack_o, bus.ifill_resp_valid_o, bus.ifill_resp_done_o, bus.ifill_resp_err_o, bus.mem_req_valid_o}, 5'b0);
      chk("midrst_data", bus.ifill_resp_data_o, 512'b0);
      chk("midrst_addr", bus.mem_req_addr_o, 40'b0);
      cyc();
      cyc();
      chk("midrst_req", 32'(reqs - r0), 32'd1);
      chk("midrst_resp", 32'(pulses - p0), 32'd0);
      fill(40'h88000001c5, 0, 0, 4, 1'b1, 4'b0000, 1'b0, 1'b0);
      for (int n = 0; n < 10; n++) begin
         mode = $urandom_range(0, 3);
         ns = mode == 2 ? $urandom_range(1, 3) : 4;
         fill({8'($urandom), $urandom}, $urandom_range(0, 6), $urandom_range(0, 15), ns, mode != 3,
              ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0, 1'($urandom), 1'($urandom));
      end
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
